// File: rtl/fifo_pkg.sv
// Shared definitions for the FIFO and its push arbiter: FSM encoding, default
// widths, and the index-width helper used by the round-robin finder.
`timescale 1ns/1ps
package fifo_pkg;

  localparam int unsigned DEF_BITS  = 16;
  localparam int unsigned DEF_DEPTH = 16;
  localparam int unsigned CNT_W     = 16;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PUSH  = 2'd1,
    STALL = 2'd2
  } arb_state_t;

  // Index width for n requesters; a single requester still needs one bit
  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin finder: first set request strictly after `last`,
// wrapping to index 0. Returns one-hot, binary index and an any-request flag.
`timescale 1ns/1ps
module rr_pick
  import fifo_pkg::*;
#(
  parameter int unsigned REQS = 4,
  localparam int unsigned IDXW = idx_width(REQS)
) (
  input  logic [REQS-1:0] req,
  input  logic [IDXW-1:0] last,
  output logic [REQS-1:0] win,
  output logic [IDXW-1:0] win_idx,
  output logic            any
);

  logic [IDXW-1:0] hi_idx;
  logic [IDXW-1:0] lo_idx;
  logic            hi_hit;
  logic            lo_hit;

  // Lowest requester above `last` beats lowest requester at or below it
  always_comb begin
    hi_idx = '0;
    lo_idx = '0;
    hi_hit = 1'b0;
    lo_hit = 1'b0;
    for (int i = int'(REQS) - 1; i >= 0; i--) begin
      if (req[i] && (IDXW'(i) > last)) begin
        hi_idx = IDXW'(i);
        hi_hit = 1'b1;
      end
      if (req[i] && (IDXW'(i) <= last)) begin
        lo_idx = IDXW'(i);
        lo_hit = 1'b1;
      end
    end
  end

  always_comb begin
    any     = hi_hit | lo_hit;
    win_idx = hi_hit ? hi_idx : lo_idx;
    win     = any ? (REQS'(1) << win_idx) : '0;
  end

endmodule

// File: rtl/fifo_push_arb.sv
// Round-robin push arbiter sharing one FIFO write port among REQS producers.
// Define FIFO_ARB_STATS_EN to build the saturating stall-cycle counter.
`timescale 1ns/1ps
module fifo_push_arb
  import fifo_pkg::*;
#(
  parameter int unsigned REQS = 4,
  parameter int unsigned BITS = DEF_BITS
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [REQS-1:0]      req,
  input  logic [REQS*BITS-1:0] Din_bus,
  input  logic                 full,
  output logic [REQS-1:0]      gnt,
  output logic                 push,
  output logic [BITS-1:0]      Din,
  output logic                 stall,
  output logic [CNT_W-1:0]     stall_cnt
);

  localparam int unsigned IDXW = idx_width(REQS);

  arb_state_t      state, state_nxt;
  logic [IDXW-1:0] last, last_nxt;
  logic [REQS-1:0] gnt_nxt;
  logic            push_nxt;
  logic [BITS-1:0] din_nxt;
  logic            stall_nxt;

  logic [REQS-1:0] win;
  logic [IDXW-1:0] win_idx;
  logic            any;
  logic [BITS-1:0] word;

  rr_pick #(.REQS(REQS)) u_pick (
    .req     (req),
    .last    (last),
    .win     (win),
    .win_idx (win_idx),
    .any     (any)
  );

  // Winner's data word
  always_comb begin
    word = '0;
    for (int unsigned i = 0; i < REQS; i++) begin
      if (win_idx == IDXW'(i)) word = Din_bus[i*BITS +: BITS];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      last  <= IDXW'(REQS - 1);
      gnt   <= '0;
      push  <= 1'b0;
      Din   <= '0;
      stall <= 1'b0;
    end else begin
      state <= state_nxt;
      last  <= last_nxt;
      gnt   <= gnt_nxt;
      push  <= push_nxt;
      Din   <= din_nxt;
      stall <= stall_nxt;
    end
  end

  // PUSH always lasts one cycle, so full seen in IDLE/STALL already counts it
  always_comb begin
    state_nxt = state;
    last_nxt  = last;
    gnt_nxt   = '0;
    push_nxt  = 1'b0;
    din_nxt   = Din;
    stall_nxt = 1'b0;
    case (state)
      IDLE, STALL: begin
        if (!any) begin
          state_nxt = IDLE;
        end else if (!full) begin
          state_nxt = PUSH;
          gnt_nxt   = win;
          push_nxt  = 1'b1;
          din_nxt   = word;
          last_nxt  = win_idx;
        end else begin
          state_nxt = STALL;
          stall_nxt = 1'b1;
        end
      end
      PUSH:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

`ifdef FIFO_ARB_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt <= '0;
    end else if ((state == STALL) && (stall_cnt != CNT_MAX)) begin
      stall_cnt <= stall_cnt + CNT_W'(1);
    end
  end
`else
  assign stall_cnt = '0;
`endif

endmodule

// File: tb/tb_fifo_push_arb.sv
// Directed bench for fifo_push_arb (REQS=4, BITS=16) feeding a 16-deep FIFO model.
`timescale 1ns/1ps
module tb_fifo_push_arb;
  import fifo_pkg::*;

  localparam int unsigned REQS = 4;
  localparam int unsigned BITS = 16;

  logic                 clk = 1'b0;
  logic                 rst;
  logic [REQS-1:0]      req;
  logic [REQS*BITS-1:0] din_bus;
  logic                 full = 1'b0;
  logic [REQS-1:0]      gnt;
  logic                 push;
  logic [BITS-1:0]      din;
  logic                 stall;
  logic [15:0]          stall_cnt;

  logic                 pop;
  logic [BITS-1:0]      dout = '0;
  logic [BITS-1:0]      q[$];

  int tests = 0;
  int fails = 0;
  int n_push;

  always #1 clk = ~clk;

  fifo_push_arb #(.REQS(REQS), .BITS(BITS)) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .Din_bus   (din_bus),
    .full      (full),
    .gnt       (gnt),
    .push      (push),
    .Din       (din),
    .stall     (stall),
    .stall_cnt (stall_cnt)
  );

  // FIFO model: pop before push, full registered like a flop FIFO
  always @(posedge clk) begin
    if (pop && q.size() > 0) begin
      dout <= q[0];
      void'(q.pop_front());
    end
    if (push && q.size() < int'(DEF_DEPTH)) q.push_back(din);
    full <= (q.size() == int'(DEF_DEPTH));
  end

  function automatic logic [31:0] exp_cnt(input int n);
`ifdef FIFO_ARB_STATS_EN
    return 32'(n);
`else
    return 32'(n * 0);
`endif
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic nedge(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    rst     = 1'b1;
    req     = '0;
    din_bus = '0;
    pop     = 1'b0;

    // Reset
    nedge(10);
    chk("rst_gnt",   32'(gnt),       32'h0);
    chk("rst_push",  32'(push),      32'h0);
    chk("rst_stall", 32'(stall),     32'h0);
    chk("rst_cnt",   32'(stall_cnt), 32'h0);
    chk("rst_din",   32'(din),       32'h0);
    rst = 1'b0;
    nedge(3);
    chk("idle_nopush", 32'(push), 32'h0);
    chk("idle_q",      32'(q.size()), 32'h0);

    // Single producer
    req = 4'b0100;
    din_bus[2*BITS +: BITS] = 16'h00A5;
    nedge(1);
    chk("single_gnt",  32'(gnt),  32'h4);
    chk("single_push", 32'(push), 32'h1);
    chk("single_din",  32'(din),  32'h00A5);
    req = '0;
    nedge(1);
    chk("single_gnt_off",  32'(gnt),  32'h0);
    chk("single_push_off", 32'(push), 32'h0);
    nedge(1);
    chk("single_q", 32'(q.size()), 32'h1);
    pop = 1'b1;
    nedge(1);
    pop = 1'b0;
    chk("single_dout", 32'(dout), 32'h00A5);

    // Fairness from reset priority
    rst = 1'b1;
    nedge(1);
    rst = 1'b0;
    req = 4'b1111;
    din_bus = {16'h0013, 16'h0012, 16'h0011, 16'h0010};
    for (int c = 0; c < 16; c++) begin
      nedge(1);
      if (c % 2 == 0) begin
        chk("fair_gnt", 32'(gnt), 32'(1) << ((c / 2) % 4));
        chk("fair_din", 32'(din), 32'h10 + 32'((c / 2) % 4));
      end else begin
        chk("fair_gap", 32'(push), 32'h0);
      end
    end
    req = '0;
    nedge(1);
    chk("fair_q", 32'(q.size()), 32'h8);
    for (int i = 0; i < 8; i++) chk("fair_order", 32'(q[i]), 32'h10 + 32'(i % 4));
    pop = 1'b1;
    nedge(8);
    pop = 1'b0;
    chk("fair_drain", 32'(q.size()), 32'h0);

    // Fill to full with producer 0
    n_push = 0;
    req = 4'b0001;
    din_bus[0 +: BITS] = 16'h0100;
    for (int t = 0; t < 100 && n_push < 16; t++) begin
      nedge(1);
      if (push) begin
        n_push++;
        din_bus[0 +: BITS] = 16'h0100 + 16'(n_push);
      end
    end
    req = '0;
    chk("fill_count", 32'(n_push), 32'd16);
    nedge(1);
    chk("fill_full", 32'(full), 32'h1);
    chk("fill_q",    32'(q.size()), 32'd16);

    // Backpressure: stall while full, push after a pop
    req = 4'b0010;
    din_bus[BITS +: BITS] = 16'hBEEF;
    nedge(1);
    chk("bp_stall",  32'(stall),     32'h1);
    chk("bp_nopush", 32'(push),      32'h0);
    chk("bp_cnt0",   32'(stall_cnt), 32'h0);
    nedge(3);
    chk("bp_stall3", 32'(stall),     32'h1);
    chk("bp_hold",   32'(push),      32'h0);
    chk("bp_cnt3",   32'(stall_cnt), exp_cnt(3));
    pop = 1'b1;
    nedge(1);
    pop = 1'b0;
    chk("bp_wait", 32'(push), 32'h0);
    nedge(1);
    chk("bp_push",    32'(push),      32'h1);
    chk("bp_gnt",     32'(gnt),       32'h2);
    chk("bp_din",     32'(din),       32'hBEEF);
    chk("bp_unstall", 32'(stall),     32'h0);
    chk("bp_cnt5",    32'(stall_cnt), exp_cnt(5));
    chk("bp_dout",    32'(dout),      32'h0100);
    req = '0;
    nedge(1);
    chk("bp_refull", 32'(full),     32'h1);
    chk("bp_q",      32'(q.size()), 32'd16);

    // Withdrawal while stalled
    req = 4'b0010;
    nedge(1);
    chk("wd_stall", 32'(stall), 32'h1);
    req = '0;
    nedge(1);
    chk("wd_unstall", 32'(stall),     32'h0);
    chk("wd_gnt",     32'(gnt),       32'h0);
    chk("wd_push",    32'(push),      32'h0);
    chk("wd_cnt6",    32'(stall_cnt), exp_cnt(6));
    nedge(1);
    chk("wd_push2", 32'(push),     32'h0);
    chk("wd_q",     32'(q.size()), 32'd16);
    pop = 1'b1;
    nedge(16);
    pop = 1'b0;
    nedge(1);
    chk("wd_drain", 32'(q.size()), 32'h0);

    // Reset during PUSH clears everything; priority restarts at producer 0
    req = 4'b0010;
    din_bus[BITS +: BITS] = 16'h7777;
    nedge(1);
    chk("rp_push", 32'(push), 32'h1);
    chk("rp_gnt",  32'(gnt),  32'h2);
    rst = 1'b1;
    req = '0;
    nedge(1);
    chk("rp_push_off", 32'(push),      32'h0);
    chk("rp_gnt_off",  32'(gnt),       32'h0);
    chk("rp_din",      32'(din),       32'h0);
    chk("rp_stall",    32'(stall),     32'h0);
    chk("rp_cnt",      32'(stall_cnt), 32'h0);
    rst = 1'b0;
    req = 4'b1111;
    din_bus = {16'h0013, 16'h0012, 16'h0011, 16'h0010};
    nedge(1);
    chk("rp_first_gnt", 32'(gnt), 32'h1);
    chk("rp_first_din", 32'(din), 32'h10);
    req = '0;
    nedge(2);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/fifo_push_arb.md
# fifo_push_arb

Round-robin push arbiter sharing one `fifo_flops` write port among `REQS` producers. Each producer raises a request with its data word; the arbiter selects one winner per slot, drives the FIFO's `push`/`Din`, and returns a one-hot grant to the winner. Upstream of `fifo_flops`: producers connect here, and the FIFO's `full` feeds back to hold off writes.

## Interface
Parameters:
- `REQS`, 4: number of producers (2..16).
- `BITS`, 16: data width, equal to the FIFO `BITS`.

Ports:
- `clk`  in  1: single clock, all logic on posedge.
- `rst`  in  1: synchronous, active-high reset.
- `req`  in  REQS: request vector, bit i = producer i has a word.
- `Din_bus`  in  REQS*BITS: producer i word at `[i*BITS +: BITS]`.
- `full`  in  1: from the FIFO.
- `gnt`  out  REQS: one-hot, high for the single cycle producer i's word is pushed.
- `push`  out  1: to the FIFO `push`.
- `Din`  out  BITS: to the FIFO `Din`.
- `stall`  out  1: high while requests are pending and the FIFO is full.
- `stall_cnt`  out  16: stall-cycle statistic (see Configuration).

## Operation
- FSM states: IDLE, PUSH, STALL. Reset state is IDLE.
- Arbitration (IDLE or STALL, evaluated combinationally):
  - Search `req` starting at `last+1` mod `REQS` and wrapping; the first set bit wins.
  - `last` is a register holding the previous winner. Reset value is `REQS-1`, so producer 0 has first priority.
- IDLE:
  - `|req && !full`: register `gnt[w]=1`, `push=1`, `Din=word w`, set `last=w`, go to PUSH.
  - `|req && full`: go to STALL, `stall=1`.
  - Otherwise stay in IDLE.
- PUSH (exactly one cycle): `push`, `gnt` and `Din` valid; the FIFO samples them on the next edge.
  - Next state is always IDLE, with `push`/`gnt` cleared.
  - A producer must hold `req` and its word stable until it sees its `gnt` bit. It deasserts or presents its next word in the cycle after `gnt`.
- STALL: `stall=1`.
  - `!full && |req`: arbitrate as in IDLE and go to PUSH.
  - `!|req`: go to IDLE.
  - Otherwise stay in STALL.
- A maximum of one push every 2 cycles. Because of this, `full` sampled in IDLE/STALL already reflects the previous push, and the arbiter never pushes into a full FIFO.
- `Din` holds its last pushed value when `push=0`.

## Timing
- All outputs are registered.
- Reset values: `gnt=0`, `push=0`, `Din=0`, `stall=0`, `stall_cnt=0`, `last=REQS-1`, state IDLE.
- Latency: `req` seen at edge k results in `push`/`gnt` high during cycle k+1 (after edge k). The FIFO captures the word at edge k+1.
- Simultaneous requests: one grant per slot. Among N continuously requesting producers, each is granted once every 2N cycles.
- `req` dropped while in STALL, before a grant: no push for that producer, and no grant is issued to a dropped requester.
- `full` rising in the same cycle as a PUSH has no effect on that push. It was decided before the push, when the FIFO had room.
- `rst` high at any edge, including during PUSH: all outputs take reset values at that edge, and no partial grant is retained.
- Wrap-around: a winner at `REQS-1` makes producer 0 next highest priority.

## Configuration
- `FIFO_ARB_STATS_EN` defined:
  - `stall_cnt` increments by 1 on every edge where the state is STALL.
  - It saturates at 16'hFFFF and is cleared only by `rst`.
- Not defined:
  - `stall_cnt` is tied to 0 and no counter logic is built.
  - The port remains, so the interface is identical.

## Structure
- Shared package / defines file `fifo_pkg`:
  - FSM state encoding: IDLE=2'd0, PUSH=2'd1, STALL=2'd2.
  - Default `BITS`/`DEPTH`, shared with `fifo_flops`.
- Sub-module `rr_pick`:
  - Combinational round-robin finder.
  - Inputs: `req`, `last`. Outputs: one-hot `win` and binary `win_idx`, plus a `any` flag.
  - Reused by later arbiters.
- Top `fifo_push_arb` holds the FSM, the registers, the data mux and the optional counter.

## Test plan
Bench wiring: `fifo_push_arb` (REQS=4, BITS=16) driving `fifo_flops` (DEPTH=16), with a 2 ns clock.

- Reset: hold `rst=1` for 10 cycles -> `gnt=0`, `push=0`, `stall=0`, `stall_cnt=0`. Release with `req=0` -> no push.
- Single producer: `req=4'b0100` with word 16'h00A5 -> `gnt=4'b0100` and `push=1` for exactly one cycle, 1 cycle after the request. FIFO `Dout`=16'h00A5 after a pop.
- Fairness: `req=4'b1111` held for 16 cycles, with words 0x10/0x11/0x12/0x13 per producer -> grant order 0,1,2,3,0,1,2,3. The FIFO holds 8 words in that order, 2 cycles apart.
- Full backpressure: fill the FIFO with 16 words -> `full=1`. A further request gives `stall=1`, no push, and `stall_cnt` counting with the macro on. Pop one word -> `full=0`, pending word pushed, `stall` cleared.
- Withdrawal: in STALL with `req=4'b0010`, drop `req` to 0 -> return to IDLE, no `gnt`, FIFO count unchanged.
- Reset mid-push: assert `rst` in the PUSH cycle -> `push=0` at the next edge, `last` reset, and the next `req=4'b1111` grants producer 0 first.
